// File: rtl/mdu_pkg.sv
// Shared definitions for ex_mdu: operation encoding, controller states and default width.
// The DIVZERO state is present only when MDU_DIV_EN is defined.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2
`ifdef MDU_DIV_EN
        ,
        DIVZERO = 2'd3
`endif
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: yields |x| from a signed operand, or
// restores the sign of a magnitude result.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    assign data_o = neg_i ? (W'(0) - data_i) : data_i;

endmodule

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide on magnitudes. Divide support is enabled by defining MDU_DIV_EN.
module ex_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               divzero_o,
    output logic               stallreq_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_res_q, neg_res_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    op_e                op_in;
    logic               a_neg, b_neg, accept, stall;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] iter_next, prod_fix, final_res;

`ifdef MDU_DIV_EN
    logic               div_q, div_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
`endif

    assign op_in  = op_e'(op_i);
    assign a_neg  = op_is_signed(op_in) & opdata1_i[WIDTH-1];
    assign b_neg  = op_is_signed(op_in) & opdata2_i[WIDTH-1];
    assign accept = (state_q == IDLE) & start_i & ~annul_i;

    mdu_sign_fix #(.W(WIDTH)) u_fix_a (.neg_i(a_neg), .data_i(opdata1_i), .data_o(a_mag));
    mdu_sign_fix #(.W(WIDTH)) u_fix_b (.neg_i(b_neg), .data_i(opdata2_i), .data_o(b_mag));

    // Multiply step: conditionally add the multiplicand into HI, then shift {HI,LO} right.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (acc_q[0]) begin
            mul_sum = mul_sum + {1'b0, b_q};
        end
    end

    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.neg_i(neg_res_q), .data_i(iter_next), .data_o(prod_fix));

`ifdef MDU_DIV_EN
    // Divide step: {rem,quo} shifts left; a borrow out of rem_diff means "restore".
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_diff = rem_sh - {1'b0, b_q};
    assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                                      : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    mdu_sign_fix #(.W(WIDTH)) u_fix_quo (.neg_i(neg_res_q), .data_i(iter_next[WIDTH-1:0]),
                                         .data_o(quo_fix));
    mdu_sign_fix #(.W(WIDTH)) u_fix_rem (.neg_i(neg_rem_q), .data_i(iter_next[2*WIDTH-1:WIDTH]),
                                         .data_o(rem_fix));

    assign iter_next = div_q ? div_next : {mul_sum, acc_q[WIDTH-1:1]};
    assign final_res = div_q ? {rem_fix, quo_fix} : prod_fix;
    assign divzero_o = (state_q == DONE) & dz_q;
`else
    assign iter_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign final_res = prod_fix;
    assign divzero_o = 1'b0;
`endif

    // NOTE: every signal gets its default first, so no path through this block infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        neg_res_d = neg_res_q;
        result_d  = result_q;
        stall     = 1'b0;
`ifdef MDU_DIV_EN
        div_d     = div_q;
        neg_rem_d = neg_rem_q;
        dz_d      = (state_q == DIVZERO);
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    cnt_d     = '0;
                    neg_res_d = a_neg ^ b_neg;
                    acc_d     = {{WIDTH{1'b0}}, b_mag};
                    b_d       = a_mag;
                    state_d   = BUSY;
`ifdef MDU_DIV_EN
                    div_d     = op_is_div(op_in);
                    neg_rem_d = a_neg;
                    if (op_is_div(op_in)) begin
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        b_d     = b_mag;
                        state_d = (opdata2_i == '0) ? DIVZERO : BUSY;
                    end
`else
                    if (op_is_div(op_in)) begin
                        state_d  = DONE;
                        result_d = '0;
                    end
`endif
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = iter_next;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DONE;
                        result_d = final_res;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef MDU_DIV_EN
            DIVZERO: begin
                stall = 1'b1;
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DONE;
                    result_d = '0;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef MDU_DIV_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
`ifdef MDU_DIV_EN
            dz_q     <= dz_d;
`endif
        end
    end

    // NOTE: datapath registers carry no reset; each is loaded on acceptance before it is read.
    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        b_q       <= b_d;
        neg_res_q <= neg_res_d;
`ifdef MDU_DIV_EN
        div_q     <= div_d;
        neg_rem_q <= neg_rem_d;
`endif
    end

    assign result_o   = result_q;
    assign ready_o    = (state_q == DONE);
    assign stallreq_o = stall & ~rst;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu (WIDTH=32): directed cases plus random operations
// against an arithmetic reference model; divide expectations follow MDU_DIV_EN.
module tb_ex_mdu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          annul_i;
    logic [1:0]    op_i;
    logic [W-1:0]  a_i, b_i;
    logic [2*W-1:0] result_o;
    logic          ready_o, divzero_o, stallreq_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_mdu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .op_i       (op_i),
        .opdata1_i  (a_i),
        .opdata2_i  (b_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .divzero_o  (divzero_o),
        .stallreq_o (stallreq_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation's meaning, plus expected latency
    // counted in clock edges after the acceptance edge's preceding request cycle.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output logic dz, output int lat);
        longint      sa, sb;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dz  = 1'b0;
        lat = W + 1;
        res = '0;
        if (op == 2'd0) begin
            res = sa * sb;
        end else if (op == 2'd1) begin
            res = {32'd0, a} * {32'd0, b};
        end else begin
`ifdef MDU_DIV_EN
            if (b == 32'd0) begin
                dz  = 1'b1;
                lat = 2;
            end else if (op == 2'd2) begin
                res = {32'(sa % sb), 32'(sa / sb)};
            end else begin
                res = {a % b, a / b};
            end
`else
            lat = 1;
`endif
        end
        return res;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [63:0] got);
        logic [63:0] exp_res;
        logic        exp_dz;
        int          exp_lat;
        int          n;
        logic        stall_ok;
        exp_res = model(op, a, b, exp_dz, exp_lat);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        #1 check({tag, ".stall_req"}, 64'(stallreq_o), 64'd1);
        @(negedge clk);
        n        = 1;
        stall_ok = 1'b1;
        start_i  = 1'b0;
        op_i     = 2'($urandom);
        a_i      = $urandom;
        b_i      = $urandom;
        while (!ready_o && n < 200) begin
            if (!stallreq_o) stall_ok = 1'b0;
            start_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        start_i = 1'b0;
        got     = result_o;
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        check({tag, ".stall_busy"}, 64'(stall_ok), 64'd1);
        check({tag, ".result"}, result_o, exp_res);
        check({tag, ".divzero"}, 64'(divzero_o), 64'(exp_dz));
        #1 check({tag, ".stall_done"}, 64'(stallreq_o), 64'd0);
        @(negedge clk);
        check({tag, ".ready_pulse"}, 64'(ready_o), 64'd0);
        check({tag, ".result_hold"}, result_o, exp_res);
        check({tag, ".divzero_idle"}, 64'(divzero_o), 64'd0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ready_o) pulses++;
        end
        check(tag, 64'(pulses), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got;
        rst     = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        op_i    = 2'd0;
        a_i     = '0;
        b_i     = '0;
        repeat (2) @(negedge clk);
        check("reset.ready", 64'(ready_o), 64'd0);
        check("reset.result", result_o, 64'd0);
        check("reset.divzero", 64'(divzero_o), 64'd0);
        check("reset.stall", 64'(stallreq_o), 64'd0);
        rst = 1'b0;

        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, got);
        check("mult_neg.value", got, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got);
        check("multu_max.value", got, 64'hFFFF_FFFE_0000_0001);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, got);
`ifdef MDU_DIV_EN
        check("div_neg.value", got, 64'hFFFF_FFFF_FFFF_FFFD);
`endif
        run_op("div_wrap", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, got);
`ifdef MDU_DIV_EN
        check("div_wrap.value", got, 64'h0000_0000_8000_0000);
`endif
        run_op("divu_zero", 2'd3, 32'd100, 32'd0, got);
        check("divu_zero.value", got, 64'd0);

        for (int i = 0; i < 30; i++) begin
            run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), pick_operand(),
                   pick_operand(), got);
        end

        // Annul a multiply at iteration 10, then run a short divide.
        @(negedge clk);
        start_i = 1'b1;
        op_i    = 2'd0;
        a_i     = 32'd1234;
        b_i     = 32'd5678;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul.stall", 64'(stallreq_o), 64'd0);
        check("annul.ready", 64'(ready_o), 64'd0);
        expect_quiet("annul.no_ready", 40);
        run_op("after_annul", 2'd3, 32'd9, 32'd4, got);
`ifdef MDU_DIV_EN
        check("after_annul.value", got, 64'h0000_0001_0000_0002);
`endif

        // Synchronous reset in the middle of an operation.
        @(negedge clk);
        start_i = 1'b1;
`ifdef MDU_DIV_EN
        op_i    = 2'd2;
`else
        op_i    = 2'd0;
`endif
        a_i     = 32'd1000;
        b_i     = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_i = 1'b1;
        #1;
        check("rst_mid.ready", 64'(ready_o), 64'd0);
        check("rst_mid.result", result_o, 64'd0);
        check("rst_mid.divzero", 64'(divzero_o), 64'd0);
        check("rst_mid.stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b0;
        expect_quiet("rst_mid.no_ready", 40);

        // start_i together with annul_i in IDLE must not be accepted.
        @(negedge clk);
        start_i = 1'b1;
        annul_i = 1'b1;
        op_i    = 2'd1;
        a_i     = 32'd3;
        b_i     = 32'd3;
        #1 check("start_annul.stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        check("start_annul.idle_stall", 64'(stallreq_o), 64'd0);
        expect_quiet("start_annul.no_ready", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_i  in  1  request to begin an operation.
REQ-005 SHALL have port annul_i  in  1  cancel the current or requested operation (flush/exception).
REQ-006 SHALL have port op_i  in  2  operation: MULT, MULTU, DIV, DIVU.
REQ-007 SHALL have port opdata1_i  in  WIDTH  multiplicand or dividend.
REQ-008 SHALL have port opdata2_i  in  WIDTH  multiplier or divisor.
REQ-009 SHALL have port result_o  out  2*WIDTH  {HI,LO}: product, or {remainder,quotient}.
REQ-010 SHALL have port ready_o  out  1  result_o valid this cycle.
REQ-011 SHALL have port divzero_o  out  1  qualifies ready_o: divisor was zero.
REQ-012 SHALL have port stallreq_o  out  1  EX stage must hold.

Function
REQ-013 SHALL implement states IDLE, BUSY, DIVZERO, DONE.
REQ-014 SHALL accept a request in IDLE when start_i=1 and annul_i=0; operands and op_i are captured at that edge and need not be held.
REQ-015 SHALL go IDLE->DIVZERO on acceptance when op is DIV/DIVU and opdata2_i=0; otherwise IDLE->BUSY with iteration counter cleared.
REQ-016 SHALL perform one radix-2 iteration per BUSY cycle (shift-add multiply, restoring divide on magnitudes) and go BUSY->DONE after exactly WIDTH iterations.
REQ-017 SHALL go DIVZERO->DONE after one cycle, with result_o all zero and divzero_o=1.
REQ-018 SHALL assert ready_o for exactly one cycle, while in DONE, then return to IDLE; for an accepted request at edge 0, ready_o is high in the cycle after edge WIDTH+1 (normal) or edge 2 (divide-by-zero).
REQ-019 SHALL hold result_o stable from DONE until the next acceptance; divzero_o is 0 except in DONE after DIVZERO.
REQ-020 SHALL, for signed ops, operate on magnitudes and negate the product or quotient when operand signs differ; the remainder takes the dividend's sign.
REQ-021 SHALL, for signed most-negative / -1, return quotient = most-negative value (two's-complement wrap) and remainder 0, with no flag.
REQ-022 SHALL drive stallreq_o = (IDLE and start_i and !annul_i) or BUSY or DIVZERO; stallreq_o SHALL be low in DONE.
REQ-023 SHALL ignore start_i in BUSY, DIVZERO and DONE.
REQ-024 SHALL, on annul_i=1 in BUSY or DIVZERO, go to IDLE at the next edge with no ready_o pulse; annul_i in DONE SHALL suppress nothing, because the result is already valid.
REQ-025 SHALL give annul_i priority over start_i in the same cycle; the request is not accepted.

Reset
REQ-026 SHALL, on rst=1 at an edge, enter IDLE, clear the counter, result_o=0, ready_o=0, divzero_o=0; stallreq_o SHALL be 0 while rst=1.
REQ-027 SHALL abandon any operation in progress when rst is asserted mid-operation, with no ready_o afterward.

Configuration
REQ-028 SHALL use macro MDU_DIV_EN: when defined, the DIV/DIVU datapath and DIVZERO state are present as above.
REQ-029 SHALL, with MDU_DIV_EN undefined, omit the divide datapath and DIVZERO state; a DIV/DIVU request goes IDLE->DONE, ready_o is high one cycle after acceptance, result_o=0 and divzero_o=0.

Structure
REQ-030 SHALL take from shared package mdu_pkg: the op encoding (MULT=0, MULTU=1, DIV=2, DIVU=3), the state enumeration and the WIDTH default.
REQ-031 SHALL instantiate exactly one sub-module, mdu_sign_fix (parametrised conditional two's-complement negate), for operand magnitudes and result correction.
REQ-032 SHALL size the iteration counter as $clog2(WIDTH)+1 bits.

Verification (WIDTH=32)
REQ-033 SHALL test MULT -3 x 5 -> result_o=0xFFFFFFFF_FFFFFFF1, ready_o one cycle after edge 33, stallreq_o high from the request cycle through edge 33.
REQ-034 SHALL test MULTU 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0xFFFFFFFE_00000001.
REQ-035 SHALL test DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; and DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 SHALL test DIVU 100 / 0 -> ready_o and divzero_o high after edge 2, result_o=0; with MDU_DIV_EN undefined -> ready_o after edge 1, divzero_o=0.
REQ-037 SHALL test annul_i at iteration 10 of a MULT -> no ready_o, stallreq_o low next cycle, and a following DIVU 9/4 returns LO=2, HI=1.
REQ-038 SHALL test rst pulsed mid-DIV -> all outputs 0 next cycle, no ready_o; and start_i with annul_i together in IDLE -> not accepted.
